// File: rtl/top_memwb.sv
// Back half of the five-stage MIPS datapath: EX/MEM register, word-addressed
// data memory, MEM/WB register and writeback select feeding top_IDEX.
module top_memwb #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] baddr_in,
  input  logic [31:0] result_in,
  input  logic        zero_in,
  input  logic [31:0] read_d2_in,
  input  logic [4:0]  write_register_in,
  input  logic [2:0]  MEM_in,
  input  logic [1:0]  WB_in,
  output logic        pcsrc,
  output logic [31:0] baddr,
  output logic        regwrite,
  output logic [4:0]  write_register,
  output logic [31:0] write_data
);

  logic [31:0] exmem_baddr;
  logic [31:0] exmem_result;
  logic        exmem_zero;
  logic [31:0] exmem_read_d2;
  logic [4:0]  exmem_write_register;
  logic [2:0]  exmem_mem;
  logic [1:0]  exmem_wb;

  logic [31:0] memwb_rdata;
  logic [31:0] memwb_result;
  logic [4:0]  memwb_write_register;
  logic [1:0]  memwb_wb;

  logic [31:0]       data_mem [DEPTH];
  logic [ADDR_W-1:0] mem_index;
  logic [31:0]       mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_baddr          <= '0;
      exmem_result         <= '0;
      exmem_zero           <= 1'b0;
      exmem_read_d2        <= '0;
      exmem_write_register <= '0;
      exmem_mem            <= '0;
      exmem_wb             <= '0;
    end else begin
      exmem_baddr          <= baddr_in;
      exmem_result         <= result_in;
      exmem_zero           <= zero_in;
      exmem_read_d2        <= read_d2_in;
      exmem_write_register <= write_register_in;
      exmem_mem            <= MEM_in;
      exmem_wb             <= WB_in;
    end
  end

  assign pcsrc = exmem_mem[2] & exmem_zero;
  assign baddr = exmem_baddr;

  // Byte offset and bits above the array size are dropped, so addresses wrap.
  assign mem_index = exmem_result[ADDR_W+1:2];
  assign mem_rdata = exmem_mem[1] ? data_mem[mem_index] : 32'd0;

  // A store held in EX/MEM is dropped if reset lands on its commit edge.
  always_ff @(posedge clk) begin
    if (!rst && exmem_mem[0]) begin
      data_mem[mem_index] <= exmem_read_d2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      memwb_rdata          <= '0;
      memwb_result         <= '0;
      memwb_write_register <= '0;
      memwb_wb             <= '0;
    end else begin
      memwb_rdata          <= mem_rdata;
      memwb_result         <= exmem_result;
      memwb_write_register <= exmem_write_register;
      memwb_wb             <= exmem_wb;
    end
  end

  assign regwrite       = memwb_wb[1];
  assign write_register = memwb_write_register;
  assign write_data     = memwb_wb[0] ? memwb_rdata : memwb_result;

endmodule

// File: tb/tb_top_memwb.sv
// Randomized bench for top_memwb against an instruction-level model that
// executes each instruction's load-then-store atomically when it leaves MEM.
module tb_top_memwb;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] baddr_in;
  logic [31:0] result_in;
  logic        zero_in;
  logic [31:0] read_d2_in;
  logic [4:0]  write_register_in;
  logic [2:0]  MEM_in;
  logic [1:0]  WB_in;
  logic        pcsrc;
  logic [31:0] baddr;
  logic        regwrite;
  logic [4:0]  write_register;
  logic [31:0] write_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] baddr;
    logic [31:0] result;
    logic        zero;
    logic [31:0] d2;
    logic [4:0]  wr;
    logic [2:0]  mem;
    logic [1:0]  wb;
  } instr_t;

  instr_t      pending;
  logic        exp_regwrite;
  logic [4:0]  exp_wr;
  logic [31:0] exp_wd;
  logic [31:0] ref_mem [DEPTH];

  top_memwb #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .baddr_in(baddr_in),
    .result_in(result_in),
    .zero_in(zero_in),
    .read_d2_in(read_d2_in),
    .write_register_in(write_register_in),
    .MEM_in(MEM_in),
    .WB_in(WB_in),
    .pcsrc(pcsrc),
    .baddr(baddr),
    .regwrite(regwrite),
    .write_register(write_register),
    .write_data(write_data)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(logic [31:0] ba, logic [31:0] res, logic z,
                                logic [31:0] d2, logic [4:0] wr,
                                logic [2:0] mem, logic [1:0] wb);
    instr_t t;
    t.baddr = ba; t.result = res; t.zero = z; t.d2 = d2;
    t.wr = wr; t.mem = mem; t.wb = wb;
    return t;
  endfunction

  function automatic instr_t nop();
    return mk(32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 3'd0, 2'd0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] expect_val);
    checks++;
    if (got !== expect_val) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
               tag, got, expect_val, $time);
    end
  endtask

  // The instruction leaving MEM reads its word, then stores, as one step.
  task automatic retire(input instr_t t);
    int idx;
    logic [31:0] loaded;
    idx = int'((t.result >> 2) % DEPTH);
    loaded = t.mem[1] ? ref_mem[idx] : 32'd0;
    if (t.mem[0]) ref_mem[idx] = t.d2;
    exp_regwrite = t.wb[1];
    exp_wr       = t.wr;
    exp_wd       = t.wb[0] ? loaded : t.result;
  endtask

  task automatic applyStimulus(input logic r, input instr_t t);
    rst               = r;
    baddr_in          = t.baddr;
    result_in         = t.result;
    zero_in           = t.zero;
    read_d2_in        = t.d2;
    write_register_in = t.wr;
    MEM_in            = t.mem;
    WB_in             = t.wb;
    @(posedge clk);
    if (r) begin
      pending      = nop();
      exp_regwrite = 1'b0;
      exp_wr       = 5'd0;
      exp_wd       = 32'd0;
    end else begin
      retire(pending);
      pending = t;
    end
    #1;
    checkOutput("pcsrc", {31'd0, pcsrc}, {31'd0, pending.mem[2] & pending.zero});
    checkOutput("baddr", baddr, pending.baddr);
    checkOutput("regwrite", {31'd0, regwrite}, {31'd0, exp_regwrite});
    checkOutput("write_register", {27'd0, write_register}, {27'd0, exp_wr});
    checkOutput("write_data", write_data, exp_wd);
  endtask

  function automatic instr_t rand_instr();
    return mk($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
              5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)));
  endfunction

  initial begin
    pending = nop();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;

    // Bring-up reset with garbage on every input.
    applyStimulus(1'b1, rand_instr());
    applyStimulus(1'b1, rand_instr());

    // Give every word a known value before anything loads.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, mk(32'd0, 32'(i * 4), 1'b0,
                             32'(i) * 32'h0101_0101 ^ 32'hA5A5_A5A5,
                             5'd0, 3'b001, 2'b00));
    end
    applyStimulus(1'b0, nop());

    // Reset with a store presented must leave memory alone.
    applyStimulus(1'b0, mk(0, 32'h40, 0, 32'hCAFE_F00D, 0, 3'b001, 2'b00));
    applyStimulus(1'b0, nop());
    applyStimulus(1'b1, mk(32'hFFFF_FFFF, 32'h40, 1, 32'hBAD0_BAD0, 5'd31, 3'b111, 2'b11));
    applyStimulus(1'b1, mk(32'h1234_0000, 32'h40, 1, 32'hBAD1_BAD1, 5'd17, 3'b111, 2'b11));
    applyStimulus(1'b0, nop());
    checkOutput("rst_pcsrc", {31'd0, pcsrc}, 32'd0);
    checkOutput("rst_baddr", baddr, 32'd0);
    checkOutput("rst_regwrite", {31'd0, regwrite}, 32'd0);
    checkOutput("rst_wr", {27'd0, write_register}, 32'd0);
    checkOutput("rst_wd", write_data, 32'd0);
    applyStimulus(1'b0, mk(0, 32'h40, 0, 0, 5'd3, 3'b010, 2'b11));
    applyStimulus(1'b0, nop());
    checkOutput("rst_mem_keep", write_data, 32'hCAFE_F00D);

    // A store caught in EX/MEM by reset is dropped.
    applyStimulus(1'b0, mk(0, 32'h44, 0, 32'h5555_5555, 0, 3'b001, 2'b00));
    applyStimulus(1'b1, nop());
    applyStimulus(1'b0, mk(0, 32'h44, 0, 0, 5'd2, 3'b010, 2'b11));
    applyStimulus(1'b0, nop());
    checkOutput("rst_drop_store", write_data, 32'd17 * 32'h0101_0101 ^ 32'hA5A5_A5A5);

    // R-type writeback.
    applyStimulus(1'b0, mk(0, 32'h0000_002A, 0, 0, 5'd9, 3'b000, 2'b10));
    checkOutput("rtype_pcsrc", {31'd0, pcsrc}, 32'd0);
    applyStimulus(1'b0, nop());
    checkOutput("rtype_regwrite", {31'd0, regwrite}, 32'd1);
    checkOutput("rtype_wr", {27'd0, write_register}, 32'd9);
    checkOutput("rtype_wd", write_data, 32'h2A);

    // Store then load of the same word, unaligned load address.
    applyStimulus(1'b0, mk(0, 32'h10, 0, 32'hDEAD_BEEF, 0, 3'b001, 2'b00));
    applyStimulus(1'b0, mk(0, 32'h13, 0, 0, 5'd4, 3'b010, 2'b11));
    applyStimulus(1'b0, nop());
    checkOutput("stld_wd", write_data, 32'hDEAD_BEEF);
    checkOutput("stld_wr", {27'd0, write_register}, 32'd4);

    // Address wrap-around.
    applyStimulus(1'b0, mk(0, 32'h400, 0, 32'h1234_5678, 0, 3'b001, 2'b00));
    applyStimulus(1'b0, mk(0, 32'h000, 0, 0, 5'd7, 3'b010, 2'b11));
    applyStimulus(1'b0, nop());
    checkOutput("wrap_wd", write_data, 32'h1234_5678);

    // Branch taken and not taken.
    applyStimulus(1'b0, nop());
    applyStimulus(1'b0, mk(32'h0040_0020, 0, 1, 0, 0, 3'b100, 2'b00));
    checkOutput("br_taken", {31'd0, pcsrc}, 32'd1);
    checkOutput("br_target", baddr, 32'h0040_0020);
    checkOutput("br_rw0", {31'd0, regwrite}, 32'd0);
    applyStimulus(1'b0, mk(32'h0040_0020, 0, 0, 0, 0, 3'b100, 2'b00));
    checkOutput("br_nottaken", {31'd0, pcsrc}, 32'd0);
    checkOutput("br_target_nt", baddr, 32'h0040_0020);
    checkOutput("br_rw1", {31'd0, regwrite}, 32'd0);
    applyStimulus(1'b0, nop());
    checkOutput("br_rw2", {31'd0, regwrite}, 32'd0);

    // Simultaneous read and write returns the old word.
    applyStimulus(1'b0, mk(0, 32'h20, 0, 32'h1111_1111, 0, 3'b001, 2'b00));
    applyStimulus(1'b0, mk(0, 32'h20, 0, 32'h2222_2222, 5'd5, 3'b011, 2'b11));
    applyStimulus(1'b0, mk(0, 32'h20, 0, 0, 5'd6, 3'b010, 2'b11));
    checkOutput("rw_old", write_data, 32'h1111_1111);
    applyStimulus(1'b0, nop());
    checkOutput("rw_new", write_data, 32'h2222_2222);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 24) == 0), rand_instr());
    end
    applyStimulus(1'b0, nop());
    applyStimulus(1'b0, nop());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/top_memwb.md
# top_memwb

Back half of the five-stage MIPS datapath: EX/MEM pipeline register, word-addressed data memory, MEM/WB pipeline register and writeback select. It consumes the EX-stage outputs of `top_IDEX` (branch target, ALU result, zero flag, store data, destination register, MEM/WB control bundles). It returns the signals `top_IDEX` takes as inputs: `pcsrc`, `baddr`, `regwrite`, `write_register`, `write_data`. Instantiating both blocks back to back closes the ID→EX→MEM→WB→ID loop.

## Interface
- `DEPTH`, 256: data memory size in 32-bit words; power of two, 4..4096.
- `ADDR_W`, 8: log2(`DEPTH`).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `baddr_in`  in  32  branch target from EX.
- `result_in`  in  32  ALU result from EX; byte address for loads/stores.
- `zero_in`  in  1  ALU zero flag from EX.
- `read_d2_in`  in  32  store data (rt value) from EX.
- `write_register_in`  in  5  destination register from EX.
- `MEM_in`  in  3  {branch, memread, memwrite}.
- `WB_in`  in  2  {regwrite, memtoreg}.
- `pcsrc`  out  1  take branch; to IF and `top_IDEX`.
- `baddr`  out  32  branch target; to IF and `top_IDEX`.
- `regwrite`  out  1  register-file write enable.
- `write_register`  out  5  register-file write address.
- `write_data`  out  32  register-file write data.

## Operation
- EX/MEM register, loaded every rising edge: baddr, result, zero, read_d2, write_register, MEM[2:0], WB[1:0].
- `pcsrc` = EX/MEM.branch & EX/MEM.zero. `baddr` = EX/MEM.baddr. Both combinational from EX/MEM only.
- Memory index = EX/MEM.result[ADDR_W+1:2].
  - Bits [1:0] are ignored. No misalignment trap.
  - Bits above ADDR_W+1 are ignored, so addresses wrap modulo 4·DEPTH bytes.
- Store: when EX/MEM.memwrite = 1, mem[index] <= EX/MEM.read_d2 at the rising edge.
- Load: read data is combinational from the array at `index`, gated to 0 when EX/MEM.memread = 0.
- MEM/WB register, loaded every rising edge: read data, EX/MEM.result, write_register, WB[1:0].
- `regwrite` = MEM/WB.regwrite. `write_register` = MEM/WB.write_register.
- `write_data` = MEM/WB.memtoreg ? MEM/WB.rdata : MEM/WB.result.
- `regwrite` is not masked for register 0; the register file is responsible for ignoring writes to $0.
- No stall or flush inputs. Hazard and flush control live upstream; a bubble is an all-zero MEM/WB bundle.

## Timing
- Reset, on an edge with `rst` = 1:
  - Every EX/MEM and MEM/WB field clears to 0.
  - Following cycle: `pcsrc`=0, `baddr`=0, `regwrite`=0, `write_register`=0, `write_data`=0.
  - Memory contents are not altered by `rst`.
  - Stores do not commit on a reset edge.
- Reset mid-operation: any store held in EX/MEM is dropped, and the in-flight writeback is cancelled.
- Latency from an instruction's EX values being sampled at edge n:
  - `pcsrc`/`baddr` valid during cycle n+1.
  - Store commits at edge n+1.
  - `regwrite`/`write_register`/`write_data` valid during cycle n+2, consumed by the register file at edge n+2.
- Store then load to the same word in consecutive instructions: the load reads the new value (write at edge k, read in cycle k+1).
- memread and memwrite both set in the same instruction: the store commits, and the load returns the pre-store value.
- Branch with zero = 0: `pcsrc` stays 0, and `baddr` still reflects the registered target.
- Back-to-back instructions are accepted every cycle, with no bubbles inserted.

## Test plan
- Reset: drive garbage inputs with `rst`=1 for 2 edges → all five outputs are 0 in the next cycle; a memwrite presented during reset leaves that word unchanged.
- R-type writeback: result_in=0x0000_002A, WB_in=2'b10, MEM_in=0, write_register_in=9 at edge n → in cycle n+2, `regwrite`=1, `write_register`=9, `write_data`=0x2A; `pcsrc`=0 throughout.
- Store/load: store 0xDEAD_BEEF to byte address 0x10 at edge n; load address 0x13 (WB_in=2'b11, dest 4) at edge n+1 → in cycle n+3, `write_data`=0xDEAD_BEEF and `write_register`=4.
- Wrap-around: with DEPTH=256, store 0x1234_5678 to 0x400; load 0x000 → reads 0x1234_5678.
- Branch: MEM_in=3'b100, zero_in=1, baddr_in=0x0040_0020 → in cycle n+1, `pcsrc`=1 and `baddr`=0x0040_0020; the same with zero_in=0 → `pcsrc`=0; `regwrite` stays 0 in both cases.
- Simultaneous read and write: word 0x20 holds 0x1111_1111; an instruction with MEM_in=3'b011, read_d2=0x2222_2222, memtoreg=1 → `write_data`=0x1111_1111; a following load of 0x20 returns 0x2222_2222.
